uart_tx_arbiter: RTL

Round-robin scheduler that shares the single `uart` transmitter among `N_REQ` byte producers. It accepts bytes over per-requester valid/ready handshakes, sequences the UART's `ld_tx_data`/`tx_enable` strobes against its `tx_empty` flag, and never loads while a frame is in flight. A watchdog flags a transmitter that fails to complete a frame. It sits between the on-chip byte sources and the `uart` TX side, clocked by the same `txclk`.

---
 rtl/uart_ctrl_pkg.sv | 21 ++
 rtl/uart_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control blocks.
//   uart_arb_state_t : TX arbiter FSM state encoding
//   DefaultTimeout   : default watchdog limit in txclk cycles
//   wrap_inc         : modular increment used for round-robin pointers
package uart_ctrl_pkg;

    localparam int unsigned DefaultTimeout = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitStart,
        StWaitDone
    } uart_arb_state_t;

    function automatic int unsigned wrap_inc(input int unsigned value,
                                             input int unsigned modulus);
        return (value + 32'd1 >= modulus) ? 32'd0 : value + 32'd1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   req_valid : per-requester request flags
//   rr_ptr    : index with highest priority this round
//   any       : at least one request is present
//   idx       : first requesting index at or after rr_ptr, searching upward with wrap
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    // rr_ptr and off are both below N_REQ, so one conditional subtract wraps.
    function automatic logic [IdxW-1:0] ptr_add(input logic [IdxW-1:0] base,
                                                input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return sum[IdxW-1:0];
    endfunction

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!any && req_valid[ptr_add(rr_ptr, k)]) begin
                any = 1'b1;
                idx = ptr_add(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
//   txclk, reset      : clock and synchronous active-high reset
//   enable            : arbitration enable
//   req_valid/data    : per-requester byte offer (byte i in req_data[8i+7:8i])
//   req_ready         : one-hot acceptance pulse, issued in the LOAD cycle
//   err_clr           : clears timeout_err
//   uart_ld_tx_data   : load strobe to the UART
//   uart_tx_data      : byte to the UART, held outside LOAD
//   uart_tx_enable    : UART shift enable
//   uart_tx_empty     : UART idle flag
//   grant_id          : index of the last granted requester
//   busy              : FSM is not idle
//   timeout_err       : sticky watchdog flag
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                     txclk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     err_clr,
    output logic                     uart_ld_tx_data,
    output logic [7:0]               uart_tx_data,
    output logic                     uart_tx_enable,
    input  logic                     uart_tx_empty,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    uart_arb_state_t state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, grant_id_q;
    logic [CntW-1:0] wd_cnt_q;
    logic [7:0]      tx_data_q;
    logic            tx_enable_q;
    logic            timeout_err_q;

    logic            pick_any;
    logic [IdxW-1:0] pick_idx;
    logic            wd_hit;
    logic            timeout_fire;

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .any       (pick_any),
        .idx       (pick_idx)
    );

    // This wait cycle is the TIMEOUT-th since the load.
    assign wd_hit = (wd_cnt_q == CntW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge txclk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a frame that completes in the limit cycle is not a timeout.
    always_comb begin
        state_d      = state_q;
        timeout_fire = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable && pick_any && uart_tx_empty) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StWaitStart;
            end
            StWaitStart: begin
                if (wd_hit) begin
                    state_d      = StIdle;
                    timeout_fire = 1'b1;
                end else if (!uart_tx_empty) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (uart_tx_empty) begin
                    state_d = StIdle;
                end else if (wd_hit) begin
                    state_d      = StIdle;
                    timeout_fire = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        busy            = (state_q != StIdle);
        uart_ld_tx_data = (state_q == StLoad);
        req_ready       = '0;
        if (state_q == StLoad) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    // Grant, pointer, watchdog and output registers
    always_ff @(posedge txclk) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            wd_cnt_q      <= '0;
            tx_data_q     <= '0;
            tx_enable_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == StIdle && state_d == StLoad) begin
                grant_id_q <= pick_idx;
                tx_data_q  <= req_data[8*pick_idx +: 8];
            end
            if (state_q == StLoad) begin
                rr_ptr_q <= IdxW'(wrap_inc(32'(grant_id_q), N_REQ));
            end

            if (state_q == StLoad || timeout_fire) begin
                wd_cnt_q <= '0;
            end else if (state_q == StWaitStart || state_q == StWaitDone) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end

            // Never gate the UART mid-frame; an enable drop lands on the return to idle.
            tx_enable_q <= (state_d != StIdle) || enable;

            if (timeout_fire) begin
                timeout_err_q <= 1'b1;
            end else if (err_clr) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign uart_tx_data   = tx_data_q;
    assign uart_tx_enable = tx_enable_q;
    assign grant_id       = grant_id_q;
    assign timeout_err    = timeout_err_q;

endmodule
